// File: rtl/multicycle_control_fsm_pkg.sv
// multicycle_control_fsm_pkg: opcodes, state encodings, control field codes and the DECODE dispatch helper.
package multicycle_control_fsm_pkg;
  localparam int OPCODE_W = 6;
  localparam int ALUOP_W = 2;
  localparam int STATE_W = 4;
  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_LW = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_BEQ = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_BNE = 6'b000101;
  localparam logic [OPCODE_W-1:0] OP_J = 6'b000010;
  localparam logic [OPCODE_W-1:0] OP_ADDI = 6'b001000;
  localparam logic [ALUOP_W-1:0] ALU_ADD = 2'b00;
  localparam logic [ALUOP_W-1:0] ALU_SUB = 2'b01;
  localparam logic [ALUOP_W-1:0] ALU_FUNCT = 2'b10;
  localparam logic [ALUOP_W-1:0] ALU_IMM = 2'b11;
  localparam logic [1:0] SRCB_RT = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;
  localparam logic [1:0] PCSRC_ALU = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP = 2'b10;
  typedef enum logic [STATE_W-1:0] {
    S_RESET, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
    S_EXEC, S_R_WB, S_BRANCH, S_JUMP, S_IMM_EXEC, S_IMM_WB
  } state_t;
  typedef struct packed {
    logic pc_write;
    logic beq;
    logic bne;
    logic iord;
    logic mem_read;
    logic mem_write;
    logic ir_write;
    logic mem_to_reg;
    logic reg_dst;
    logic reg_write;
    logic alu_src_a;
    logic [1:0] alu_src_b;
    logic [ALUOP_W-1:0] alu_op;
    logic [1:0] pc_source;
    logic instr_done;
  } ctrl_t;
  // S_FETCH doubles as the "unsupported opcode" marker
  function automatic state_t dispatch(input logic [OPCODE_W-1:0] op);
    return op == OP_RTYPE ? S_EXEC :
           (op == OP_LW || op == OP_SW) ? S_MEM_ADDR :
           (op == OP_BEQ || op == OP_BNE) ? S_BRANCH :
           op == OP_J ? S_JUMP :
           op == OP_ADDI ? S_IMM_EXEC : S_FETCH;
  endfunction
endpackage

// File: rtl/multicycle_control_fsm_if.sv
// multicycle_control_fsm_if: opcode/mem_ready in, datapath control out; mem_ready only with MEM_STALL_EN.
interface multicycle_control_fsm_if;
  import multicycle_control_fsm_pkg::*;
  logic [OPCODE_W-1:0] i_opcode;
`ifdef MEM_STALL_EN
  logic i_mem_ready;
`endif
  logic o_pc_write;
  logic o_beq;
  logic o_bne;
  logic o_iord;
  logic o_mem_read;
  logic o_mem_write;
  logic o_ir_write;
  logic o_mem_to_reg;
  logic o_reg_dst;
  logic o_reg_write;
  logic o_alu_src_a;
  logic [1:0] o_alu_src_b;
  logic [ALUOP_W-1:0] o_alu_op;
  logic [1:0] o_pc_source;
  logic o_illegal_op;
  logic o_instr_done;
  modport master (
`ifdef MEM_STALL_EN
    input i_mem_ready,
`endif
    input i_opcode,
    output o_pc_write, o_beq, o_bne, o_iord, o_mem_read, o_mem_write, o_ir_write,
    output o_mem_to_reg, o_reg_dst, o_reg_write, o_alu_src_a, o_alu_src_b, o_alu_op,
    output o_pc_source, o_illegal_op, o_instr_done
  );
  modport slave (
`ifdef MEM_STALL_EN
    output i_mem_ready,
`endif
    output i_opcode,
    input o_pc_write, o_beq, o_bne, o_iord, o_mem_read, o_mem_write, o_ir_write,
    input o_mem_to_reg, o_reg_dst, o_reg_write, o_alu_src_a, o_alu_src_b, o_alu_op,
    input o_pc_source, o_illegal_op, o_instr_done
  );
endinterface

// File: rtl/multicycle_control_fsm_decode.sv
// multicycle_control_fsm_decode: pure combinational state -> control word; unreachable states give all zeros.
module multicycle_control_fsm_decode
  import multicycle_control_fsm_pkg::*;
(
  input  state_t i_state,
  input  logic   i_is_bne,
  input  logic   i_ready,
  output ctrl_t  o_ctrl
);
  // i_ready only drops below 1 in stall builds; it gates the side effects of memory states
  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.ir_write = i_ready;
        o_ctrl.pc_write = i_ready;
        o_ctrl.alu_src_b = SRCB_FOUR;
        o_ctrl.alu_op = ALU_ADD;
      end
      S_DECODE: begin
        o_ctrl.alu_src_b = SRCB_IMM_SH;
        o_ctrl.alu_op = ALU_ADD;
      end
      S_MEM_ADDR: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.alu_op = ALU_ADD;
      end
      S_MEM_RD: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.iord = 1'b1;
      end
      S_MEM_WB: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      S_MEM_WR: begin
        o_ctrl.mem_write = 1'b1;
        o_ctrl.iord = 1'b1;
        o_ctrl.instr_done = i_ready;
      end
      S_EXEC: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_RT;
        o_ctrl.alu_op = ALU_FUNCT;
      end
      S_R_WB: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.reg_dst = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_op = ALU_SUB;
        o_ctrl.pc_source = PCSRC_ALUOUT;
        o_ctrl.beq = !i_is_bne;
        o_ctrl.bne = i_is_bne;
        o_ctrl.instr_done = 1'b1;
      end
      S_JUMP: begin
        o_ctrl.pc_write = 1'b1;
        o_ctrl.pc_source = PCSRC_JUMP;
        o_ctrl.instr_done = 1'b1;
      end
      S_IMM_EXEC: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.alu_op = ALU_IMM;
      end
      S_IMM_WB: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      default: o_ctrl = '0;
    endcase
  end
endmodule

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: multi-cycle MIPS main control (state register, next state, opcode-derived latches).
// Define MEM_STALL_EN to hold FETCH/MEM_RD/MEM_WR until i_mem_ready.
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
(
  input logic clk,
  input logic rst_n,
  multicycle_control_fsm_if.master bus
);
  state_t r_state;
  logic r_is_bne;
  logic r_is_sw;
  logic w_ready;
  ctrl_t w_ctrl;
`ifdef MEM_STALL_EN
  assign w_ready = bus.i_mem_ready;
`else
  assign w_ready = 1'b1;
`endif
  // opcode is only looked at in DECODE; branch and load/store flavour are remembered from there
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RESET;
      r_is_bne <= 1'b0;
      r_is_sw <= 1'b0;
    end else begin
      if (r_state == S_DECODE) begin
        r_is_bne <= bus.i_opcode == OP_BNE;
        r_is_sw <= bus.i_opcode == OP_SW;
      end
      case (r_state)
        S_RESET:    r_state <= S_FETCH;
        S_FETCH:    r_state <= w_ready ? S_DECODE : S_FETCH;
        S_DECODE:   r_state <= dispatch(bus.i_opcode);
        S_MEM_ADDR: r_state <= r_is_sw ? S_MEM_WR : S_MEM_RD;
        S_MEM_RD:   r_state <= w_ready ? S_MEM_WB : S_MEM_RD;
        S_MEM_WR:   r_state <= w_ready ? S_FETCH : S_MEM_WR;
        S_EXEC:     r_state <= S_R_WB;
        S_IMM_EXEC: r_state <= S_IMM_WB;
        default:    r_state <= S_FETCH;
      endcase
    end
  end
  multicycle_control_fsm_decode u_decode (
    .i_state(r_state),
    .i_is_bne(r_is_bne),
    .i_ready(w_ready),
    .o_ctrl(w_ctrl)
  );
  assign bus.o_pc_write = w_ctrl.pc_write;
  assign bus.o_beq = w_ctrl.beq;
  assign bus.o_bne = w_ctrl.bne;
  assign bus.o_iord = w_ctrl.iord;
  assign bus.o_mem_read = w_ctrl.mem_read;
  assign bus.o_mem_write = w_ctrl.mem_write;
  assign bus.o_ir_write = w_ctrl.ir_write;
  assign bus.o_mem_to_reg = w_ctrl.mem_to_reg;
  assign bus.o_reg_dst = w_ctrl.reg_dst;
  assign bus.o_reg_write = w_ctrl.reg_write;
  assign bus.o_alu_src_a = w_ctrl.alu_src_a;
  assign bus.o_alu_src_b = w_ctrl.alu_src_b;
  assign bus.o_alu_op = w_ctrl.alu_op;
  assign bus.o_pc_source = w_ctrl.pc_source;
  assign bus.o_instr_done = w_ctrl.instr_done;
  assign bus.o_illegal_op = r_state == S_DECODE && dispatch(bus.i_opcode) == S_FETCH;
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: per-instruction micro-step model checked every cycle, plus literal spot checks.
module tb_multicycle_control_fsm;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ready = 1'b1;
  int total = 0;
  int bad = 0;
  logic chk_en = 1'b0;
  logic [18:0] exp_v = '0;
  logic [18:0] act;
  logic [18:0] snap [1:16];
  string tag = "";
  int last_dones, last_done_at;
  logic last_wr_any;
  multicycle_control_fsm_if bus();
  multicycle_control_fsm dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`ifdef MEM_STALL_EN
  assign bus.i_mem_ready = ready;
`endif
  always #5 clk = ~clk;
  assign act = {bus.o_pc_write, bus.o_beq, bus.o_bne, bus.o_iord, bus.o_mem_read, bus.o_mem_write,
                bus.o_ir_write, bus.o_mem_to_reg, bus.o_reg_dst, bus.o_reg_write, bus.o_alu_src_a,
                bus.o_alu_src_b, bus.o_alu_op, bus.o_pc_source, bus.o_illegal_op, bus.o_instr_done};
  function automatic logic legal(input logic [5:0] op);
    return op inside {6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h08};
  endfunction
  function automatic int ilen(input logic [5:0] op);
    case (op)
      6'h00: return 4;
      6'h23: return 5;
      6'h2b: return 4;
      6'h04, 6'h05: return 3;
      6'h02: return 3;
      6'h08: return 4;
      default: return 2;
    endcase
  endfunction
  // expected control word for micro-step `step` of an instruction, in the order of `act`
  function automatic logic [18:0] exp_vec(input logic [5:0] op, input int step);
    logic pcw = 0, beq = 0, bne = 0, iord = 0, mr = 0, mw = 0, irw = 0, m2r = 0;
    logic rdst = 0, rw = 0, srca = 0, ill = 0, done = 0;
    logic [1:0] srcb = 0, aluop = 0, pcsrc = 0;
    if (step == 0) begin
      mr = 1; irw = 1; pcw = 1; srcb = 2'b01;
    end else if (step == 1) begin
      srcb = 2'b11; ill = !legal(op);
    end else case (op)
      6'h00: if (step == 2) begin srca = 1; aluop = 2'b10; end
             else begin rw = 1; rdst = 1; done = 1; end
      6'h23: if (step == 2) begin srca = 1; srcb = 2'b10; end
             else if (step == 3) begin mr = 1; iord = 1; end
             else begin rw = 1; m2r = 1; done = 1; end
      6'h2b: if (step == 2) begin srca = 1; srcb = 2'b10; end
             else begin mw = 1; iord = 1; done = 1; end
      6'h04, 6'h05: begin
        srca = 1; aluop = 2'b01; pcsrc = 2'b01; beq = op == 6'h04; bne = op == 6'h05; done = 1;
      end
      6'h02: begin pcw = 1; pcsrc = 2'b10; done = 1; end
      6'h08: if (step == 2) begin srca = 1; srcb = 2'b10; aluop = 2'b11; end
             else begin rw = 1; done = 1; end
      default: ;
    endcase
    return {pcw, beq, bne, iord, mr, mw, irw, m2r, rdst, rw, srca, srcb, aluop, pcsrc, ill, done};
  endfunction
  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      total++;
      if (act !== exp_v) begin
        bad++;
        $display("FAIL %s: got %b want %b", tag, act, exp_v);
      end
    end
  end
  task automatic lit(input string n, input int a, input int e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", n, a, e);
    end
  endtask
  // called at a negedge (or just after) while the DUT sits in FETCH
  task automatic run_instr(input logic [5:0] op, input int stall_step, input int nstall,
                           input int stop_step, input string name);
    int step = 0, st = nstall, cyc = 0, dones = 0, done_at = 0;
    logic wr_any = 0;
    chk_en = 1'b1;
    while (step < ilen(op) && step != stop_step) begin
      cyc++;
      bus.i_opcode = op;
      ready = !(step == stall_step && st > 0);
      exp_v = exp_vec(op, step);
      if (!ready) begin
        exp_v[18] = 1'b0; exp_v[12] = 1'b0; exp_v[0] = 1'b0;
      end
      tag = $sformatf("%s step%0d cyc%0d", name, step, cyc);
      #1;
      snap[cyc] = act;
      if (bus.o_instr_done) begin dones++; done_at = cyc; end
      if (bus.o_reg_write || bus.o_mem_write) wr_any = 1'b1;
      if (ready) step++; else st--;
      @(negedge clk);
    end
    ready = 1'b1;
    last_dones = dones;
    last_done_at = done_at;
    last_wr_any = wr_any;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.i_opcode = 6'h00;
    repeat (2) @(negedge clk);
    #1 lit("reset_held_zero", int'(act), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 lit("reset_release_zero", int'(act), 0);
    @(negedge clk);
    #1 lit("fetch_after_release_memread", int'(bus.o_mem_read), 1);
    run_instr(6'h00, -1, 0, -1, "rtype");
    lit("rtype_latency", last_done_at, 4);
    lit("rtype_done_count", last_dones, 1);
    lit("rtype_c4_regwrite_regdst", int'({snap[4][9], snap[4][10]}), 3);
    run_instr(6'h23, -1, 0, -1, "lw");
    lit("lw_latency", last_done_at, 5);
    lit("lw_memtoreg_wb", int'(snap[5][11]), 1);
    run_instr(6'h2b, -1, 0, -1, "sw");
    lit("sw_latency", last_done_at, 4);
    lit("sw_memwrite_c4", int'(snap[4][13]), 1);
    run_instr(6'h04, -1, 0, -1, "beq");
    lit("beq_latency", last_done_at, 3);
    lit("beq_flags", int'(snap[3][17:16]), 2);
    lit("beq_pcsource", int'(snap[3][3:2]), 1);
    run_instr(6'h05, -1, 0, -1, "bne");
    lit("bne_latency", last_done_at, 3);
    lit("bne_flags", int'(snap[3][17:16]), 1);
    run_instr(6'h3b, -1, 0, -1, "illegal");
    lit("illegal_pulse_decode", int'(snap[2][1]), 1);
    lit("illegal_no_done", last_dones, 0);
    lit("illegal_no_write", int'(last_wr_any), 0);
    run_instr(6'h02, -1, 0, -1, "jump");
    lit("jump_latency", last_done_at, 3);
    run_instr(6'h08, -1, 0, -1, "addi");
    lit("addi_latency", last_done_at, 4);
    run_instr(6'h05, -1, 0, -1, "bne2");
    run_instr(6'h04, -1, 0, -1, "beq2");
    lit("beq_after_bne_flags", int'(snap[3][17:16]), 2);
    run_instr(6'h00, -1, 0, 2, "rtype_abort");
    chk_en = 1'b0;
    #1 lit("exec_aluop_before_reset", int'(bus.o_alu_op), 2);
    rst_n = 1'b0;
    #1 lit("reset_async_zero", int'(act), 0);
    @(posedge clk);
    #1 lit("reset_held_after_edge", int'(act), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 lit("reset_release2_zero", int'(act), 0);
    @(negedge clk);
    run_instr(6'h08, -1, 0, -1, "addi_after_reset");
    lit("addi_after_reset_latency", last_done_at, 4);
`ifdef MEM_STALL_EN
    run_instr(6'h23, 3, 3, -1, "lw_stall");
    lit("lw_stall_latency", last_done_at, 8);
    lit("lw_stall_done_count", last_dones, 1);
    run_instr(6'h2b, 3, 2, -1, "sw_stall");
    lit("sw_stall_latency", last_done_at, 6);
    run_instr(6'h00, 0, 2, -1, "fetch_stall");
    lit("fetch_stall_latency", last_done_at, 6);
`endif
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
